// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit serializer.
// Contents: FSM state enum, default word width, counter-width helper.
package ser_pkg;

    localparam int unsigned DEF_WORD_W = 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    // Bits needed to count 0..w inclusive.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the serial pattern detectors.
// Buffers one word ahead of the shifter so consecutive words stream with
// no gap, and emits one bit per bit_en_i strobe as a registered
// data_o/valid_o pair.
// Optional build macro SER_PARITY_EN: appends an even-parity bit to every
// word; word_done_o then marks the parity bit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   word_i/word_valid_i      parallel word and its valid
//   word_ready_o             holding register empty
//   bit_en_i                 bit-rate strobe
//   data_o/valid_o           serial bit and its one-cycle qualifier
//   word_done_o              pulse with the final bit of a word
//   busy_o                   shifting, or a word is held
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic              bit_en_i,
    output logic              data_o,
    output logic              valid_o,
    output logic              word_done_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = cnt_w(WORD_W);
`ifdef SER_PARITY_EN
    localparam int unsigned LAST_CNT = WORD_W;
`else
    localparam int unsigned LAST_CNT = WORD_W - 1;
`endif

    ser_state_t        state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              data_d, valid_d, done_d, ready_d, busy_d;
    logic              cur_bit, is_last;
`ifdef SER_PARITY_EN
    logic              par_q, par_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            sh_q         <= '0;
            cnt_q        <= '0;
            data_o       <= 1'b0;
            valid_o      <= 1'b0;
            word_done_o  <= 1'b0;
            word_ready_o <= 1'b1;
            busy_o       <= 1'b0;
`ifdef SER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            data_o       <= data_d;
            valid_o      <= valid_d;
            word_done_o  <= done_d;
            word_ready_o <= ready_d;
            busy_o       <= busy_d;
`ifdef SER_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    // Next-state, handshake and shifter control.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        data_d      = data_o;
        valid_d     = 1'b0;
        done_d      = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif

        cur_bit = MSB_FIRST ? sh_q[WORD_W-1] : sh_q[0];
        is_last = (cnt_q == CNT_W'(LAST_CNT));

        // Acceptance and reload are mutually exclusive: one needs the slot
        // empty, the other needs it full.
        if (word_valid_i && !hold_full_q) begin
            hold_d      = word_i;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
`ifdef SER_PARITY_EN
                    par_d       = ^hold_q;
`endif
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_en_i) begin
                    valid_d = 1'b1;
`ifdef SER_PARITY_EN
                    data_d  = is_last ? par_q : cur_bit;
`else
                    data_d  = cur_bit;
`endif
                    if (is_last) begin
                        done_d = 1'b1;
                        // Reload from the holding register with no bubble.
                        if (hold_full_q) begin
                            sh_d        = hold_q;
                            hold_full_d = 1'b0;
                            cnt_d       = '0;
`ifdef SER_PARITY_EN
                            par_d       = ^hold_q;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sh_d  = MSB_FIRST ? {sh_q[WORD_W-2:0], 1'b0}
                                          : {1'b0, sh_q[WORD_W-1:1]};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered copies of functions of the next state.
        ready_d = !hold_full_d;
        busy_d  = (state_d == S_SHIFT) || hold_full_d;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: one MSB-first and one
// LSB-first instance share all inputs; checks select one instance's outputs.
module tb_bit_serializer;

    localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] word;
    logic         word_valid;
    logic         bit_en;
    logic         sel;

    logic m_ready, m_data, m_valid, m_done, m_busy;
    logic l_ready, l_data, l_valid, l_done, l_busy;
    logic s_ready, s_data, s_valid, s_done, s_busy;

    int tests = 0;
    int fails = 0;
    int first_cyc = -1;

    logic         exp_bit[$];
    logic         exp_done[$];
    logic [W-1:0] feed_q[$];

    bit_serializer #(.WORD_W(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .word_i(word), .word_valid_i(word_valid),
        .word_ready_o(m_ready), .bit_en_i(bit_en), .data_o(m_data),
        .valid_o(m_valid), .word_done_o(m_done), .busy_o(m_busy)
    );

    bit_serializer #(.WORD_W(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .word_i(word), .word_valid_i(word_valid),
        .word_ready_o(l_ready), .bit_en_i(bit_en), .data_o(l_data),
        .valid_o(l_valid), .word_done_o(l_done), .busy_o(l_busy)
    );

    always_comb begin
        s_ready = sel ? l_ready : m_ready;
        s_data  = sel ? l_data  : m_data;
        s_valid = sel ? l_valid : m_valid;
        s_done  = sel ? l_done  : m_done;
        s_busy  = sel ? l_busy  : m_busy;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected serial bits of one word, plus its parity bit when enabled.
    task automatic push_word(input logic [W-1:0] w, input bit msb);
        for (int i = 0; i < int'(W); i++) begin
            exp_bit.push_back(msb ? w[W-1-i] : w[i]);
            exp_done.push_back(i == int'(NB) - 1);
        end
`ifdef SER_PARITY_EN
        exp_bit.push_back(^w);
        exp_done.push_back(1'b1);
`endif
    endtask

    // Feed queued words, strobe bit_en every `period` cycles and check every
    // emitted bit, its done flag, pulse spacing and data hold between pulses.
    task automatic run_stream(input string tag, input int period,
                              input int stop_after, input int budget);
        int   seen;
        int   last_cyc;
        logic last_bit;
        bit   acc;
        seen      = 0;
        last_cyc  = 0;
        last_bit  = 1'b0;
        first_cyc = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            word_valid = (feed_q.size() > 0);
            if (word_valid) word = feed_q[0];
            bit_en = ((cyc % period) == 0);
            acc    = word_valid && s_ready;
            tick();
            if (acc) begin
                void'(feed_q.pop_front());
                chk({tag, "_ready_drop"}, 32'(s_ready), 32'd0);
            end
            if (s_valid) begin
                if (exp_bit.size() == 0) begin
                    chk({tag, "_extra_valid"}, 32'(s_valid), 32'd0);
                end else begin
                    chk({tag, "_bit"}, 32'(s_data), 32'(exp_bit.pop_front()));
                    chk({tag, "_done"}, 32'(s_done), 32'(exp_done.pop_front()));
                    if (seen > 0) chk({tag, "_gap"}, 32'(cyc - last_cyc), 32'(period));
                    else first_cyc = cyc;
                    seen++;
                    last_cyc = cyc;
                    last_bit = s_data;
                    if (stop_after > 0 && seen == stop_after) break;
                end
            end else begin
                chk({tag, "_done_idle"}, 32'(s_done), 32'd0);
                if (seen > 0) chk({tag, "_hold"}, 32'(s_data), 32'(last_bit));
            end
        end
        word_valid = 1'b0;
        bit_en     = 1'b0;
        if (stop_after == 0) chk({tag, "_all_bits"}, 32'(exp_bit.size()), 32'd0);
        exp_bit.delete();
        exp_done.delete();
        feed_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        word       = '0;
        word_valid = 1'b0;
        bit_en     = 1'b1;
        sel        = 1'b0;

        // Reset, then idle with bit_en high and no words.
        tick();
        tick();
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_done",  32'(s_done),  32'd0);
        chk("rst_data",  32'(s_data),  32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_busy",  32'(s_busy),  32'd0);
        rst = 1'b0;
        run_stream("idle", 1, 0, 10);
        chk("idle_ready", 32'(s_ready), 32'd1);
        chk("idle_busy",  32'(s_busy),  32'd0);

        // Single word 0xD0, MSB first: 1,1,0,1,0,0,0,0.
        push_word(8'hD0, 1'b1);
        feed_q.push_back(8'hD0);
        run_stream("single", 1, 0, 20);
        chk("single_latency", 32'(first_cyc), 32'd2);
        chk("single_busy_end", 32'(s_busy), 32'd0);

        // Back-to-back 0xA5 then 0x3C: contiguous bits across the boundary.
        push_word(8'hA5, 1'b1);
        push_word(8'h3C, 1'b1);
        feed_q.push_back(8'hA5);
        feed_q.push_back(8'h3C);
        run_stream("b2b", 1, 0, 40);

        // Strobe every 4th cycle, word 0x81.
        push_word(8'h81, 1'b1);
        feed_q.push_back(8'h81);
        run_stream("pace", 4, 0, 60);

        // Reset after three bits of 0xFF with 0x0F held behind it.
        push_word(8'hFF, 1'b1);
        feed_q.push_back(8'hFF);
        feed_q.push_back(8'h0F);
        run_stream("mid", 1, 3, 30);
        chk("mid_held_ready", 32'(s_ready), 32'd0);
        chk("mid_held_busy",  32'(s_busy),  32'd1);
        rst    = 1'b1;
        bit_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(s_valid), 32'd0);
        chk("mid_rst_done",  32'(s_done),  32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd1);
        chk("mid_rst_busy",  32'(s_busy),  32'd0);
        run_stream("post_rst", 1, 0, 20);

        // LSB-first instance, word 0x07: 1,1,1,0,0,0,0,0 (+ parity 1).
        sel = 1'b1;
        push_word(8'h07, 1'b0);
        feed_q.push_back(8'h07);
        run_stream("lsb", 1, 0, 20);
        chk("lsb_latency", 32'(first_cyc), 32'd2);
        chk("lsb_ready_end", 32'(s_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial converter that feeds the serial pattern detectors (data_i/valid_i bit-stream interface).
- Accepts WORD_W-bit words over a valid/ready handshake and buffers one word ahead so words stream back-to-back.
- Shifts words out one bit per bit_en_i strobe as a registered data_o/valid_o pair that wires directly to a detector's data_i/valid_i.

Parameters:
WORD_W, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WORD_W-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
word_i  input  WORD_W  parallel word to send
word_valid_i  input  1  word_i valid
word_ready_o  output  1  holding register empty; a word is accepted when word_valid_i && word_ready_o
bit_en_i  input  1  bit-rate strobe; one bit is emitted per cycle with bit_en_i=1 while in SHIFT
data_o  output  1  serial bit (to detector data_i)
valid_o  output  1  one-cycle qualifier for data_o (to detector valid_i)
word_done_o  output  1  one-cycle pulse coincident with valid_o of the final bit of a word
busy_o  output  1  state==SHIFT or holding register full

Behaviour:
Reset (rst=1 at a clk edge):
- data_o=0, valid_o=0, word_done_o=0, busy_o=0, word_ready_o=1.
- State IDLE; holding register empty; shifter and bit counter cleared.
- Reset mid-word aborts the word. The partial word and any held word are discarded. No word_done_o is generated.

Storage:
- Holding register hold_q with flag hold_full.
- Shift register sh_q, WORD_W bits.
- Bit counter cnt_q, $clog2(WORD_W+1) bits.

Handshake:
- word_ready_o = !hold_full. It depends only on registered state, with no combinational path from word_valid_i.
- On acceptance, hold_q <= word_i and hold_full <= 1 at that edge.
- word_i is ignored when word_valid_i=0 or word_ready_o=0.

State machine (IDLE, SHIFT):
- IDLE: if hold_full, then sh_q <= hold_q, hold_full <= 0, cnt_q <= 0, go SHIFT. bit_en_i is ignored in IDLE.
- SHIFT, bit_en_i=1 and not the last bit:
  - data_o <= current bit (sh_q MSB if MSB_FIRST, else LSB); valid_o <= 1.
  - Shift sh_q; cnt_q++.
- SHIFT, bit_en_i=1 and last bit (cnt_q==WORD_W-1): emit as above and set word_done_o <= 1. Then:
  - if hold_full, reload the shifter from hold_q and clear hold_full at the same edge, staying in SHIFT (no bubble between words);
  - else go IDLE.
- SHIFT, bit_en_i=0: valid_o <= 0, word_done_o <= 0. data_o, sh_q and cnt_q hold.

Outputs:
- valid_o and word_done_o are 0 in every cycle except emitting cycles.
- data_o retains its last emitted value when valid_o=0.

Latency:
- A word accepted at edge N into an empty block reaches the shifter at edge N+1.
- Its first bit is registered at the first edge >=N+2 with bit_en_i=1.

Simultaneous events:
- Acceptance into the holding register and a shifter reload from it cannot coincide, because ready=0 while full.
- The slot frees at the reload edge; the next acceptance is possible the following cycle.

Optional Feature:
Macro SER_PARITY_EN.
- Defined:
  - After the last data bit, the block spends one extra bit_en_i slot emitting the even parity bit (XOR of all WORD_W data bits of that word) with valid_o=1.
  - word_done_o moves to the parity bit cycle. The data bits emitted before it carry no word_done_o.
  - cnt_q terminal count becomes WORD_W.
  - Reload/IDLE decisions happen on the parity bit edge.
- Undefined: exactly WORD_W bits per word, no parity logic present.

Decomposition:
- Package ser_pkg:
  - state enum ser_state_t {S_IDLE, S_SHIFT};
  - localparam default WORD_W=8;
  - function cnt_w(w) returning $clog2(w+1).
- Single module. The shifter/counter is too small to justify a sub-module.

Test Plan:
- Reset then idle: rst 2 cycles, bit_en_i=1 continuously, no words -> valid_o=0, word_ready_o=1, busy_o=0 throughout.
- Single word, MSB_FIRST=1, bit_en_i=1 every cycle, word 8'hD0 -> data_o sequence 1,1,0,1,0,0,0,0 on 8 consecutive valid_o cycles. word_done_o is set only on the 8th. A downstream BBCBC/11010 Moore detector flags the pattern.
- Back-to-back: words 8'hA5 then 8'h3C presented continuously, bit_en_i=1 -> 16 consecutive valid_o cycles with no gap, bits 10100101 00111100. word_ready_o drops while the holding register is full.
- Strobe pacing: bit_en_i=1 every 4th cycle, word 8'h81 -> valid_o only on strobe cycles, 8 pulses spaced 4 cycles apart. data_o holds between pulses.
- Reset mid-word: word 8'hFF, rst asserted after 3 bits with a second word held -> no further valid_o and no word_done_o; after reset, word_ready_o=1 and busy_o=0.
- SER_PARITY_EN defined, MSB_FIRST=0, word 8'h07 -> 9 valid_o bits 1,1,1,0,0,0,0,0 then parity 1. word_done_o is set on the 9th bit only.
